reseller_ctrl: RTL and testbench

- Transaction sequencer for the vending datapath.
- Owns the money accumulator's lock and clear controls. It latches the selected item price, opens the accumulator for coins, and checks the accumulated amount against the price on a buy request.
- On a successful buy it sequences dispense, change payout and accumulator clear. On cancel or timeout it refunds the full amount.

---
 rtl/reseller_ctrl.sv | 145 ++++++++++++++
 tb/tb_reseller_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reseller_ctrl.sv
// Vending transaction sequencer: latches the item price, gates coin acceptance,
// and sequences the buy/refund flows (dispense, unit change payout, accumulator clear).
module reseller_ctrl #(
  parameter int DISP_CYCLES = 4,
  parameter int TIMEOUT     = 1000
) (
  input  logic       cp,
  input  logic       rst,
  input  logic       sel_valid,
  input  logic [7:0] sel_price,
  input  logic       buy,
  input  logic       cancel,
  input  logic [7:0] moneyv,
  output logic       acc_lock,
  output logic       acc_rst,
  output logic       dispense,
  output logic       change_pulse,
  output logic [7:0] change_left,
  output logic       err_short,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    DISPENSE = 3'd2,
    CHANGE   = 3'd3,
    CLEAR    = 3'd4
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);
  localparam logic [3:0]  DISP_LAST  = 4'(DISP_CYCLES - 1);

  state_t      cur, nxt;
  logic [7:0]  price, price_nxt;
  logic [7:0]  moneyv_prev;
  logic [7:0]  change_left_nxt;
  logic [15:0] timer, timer_nxt;
  logic [3:0]  disp_cnt, disp_cnt_nxt;
  logic        phase, phase_nxt;
  logic        err_short_nxt;
  logic        change_pulse_nxt;

  always_comb begin
    nxt              = cur;
    price_nxt        = price;
    timer_nxt        = timer;
    disp_cnt_nxt     = disp_cnt;
    phase_nxt        = phase;
    change_left_nxt  = change_left;
    err_short_nxt    = 1'b0;
    change_pulse_nxt = 1'b0;
    unique case (cur)
      IDLE: begin
        if (sel_valid && (sel_price != 8'd0)) begin
          price_nxt = sel_price;
          timer_nxt = 16'd0;
          nxt       = COLLECT;
        end
      end
      COLLECT: begin
        // cancel beats buy beats timeout; a moneyv change restarts the idle count
        if (cancel) begin
          change_left_nxt = moneyv;
          phase_nxt       = 1'b0;
          nxt             = CHANGE;
        end else if (buy && (moneyv >= price)) begin
          change_left_nxt = moneyv - price;
          disp_cnt_nxt    = 4'd0;
          nxt             = DISPENSE;
        end else if (buy) begin
          err_short_nxt = 1'b1;
          timer_nxt     = 16'd0;
        end else if (moneyv != moneyv_prev) begin
          timer_nxt = 16'd0;
        end else if (timer == TIMER_LAST) begin
          change_left_nxt = moneyv;
          phase_nxt       = 1'b0;
          nxt             = CHANGE;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end
      DISPENSE: begin
        if (disp_cnt == DISP_LAST) begin
          phase_nxt = 1'b0;
          nxt       = CHANGE;
        end else begin
          disp_cnt_nxt = disp_cnt + 4'd1;
        end
      end
      CHANGE: begin
        // phase=1 is the mandatory gap after each pulse
        if (phase) begin
          phase_nxt = 1'b0;
        end else if (change_left == 8'd0) begin
          nxt = CLEAR;
        end else begin
          change_pulse_nxt = 1'b1;
          change_left_nxt  = change_left - 8'd1;
          phase_nxt        = 1'b1;
        end
      end
      CLEAR: begin
        nxt = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge cp) begin
    if (!rst) begin
      cur          <= IDLE;
      price        <= 8'd0;
      moneyv_prev  <= 8'd0;
      timer        <= 16'd0;
      disp_cnt     <= 4'd0;
      phase        <= 1'b0;
      acc_lock     <= 1'b1;
      acc_rst      <= 1'b1;
      dispense     <= 1'b0;
      change_pulse <= 1'b0;
      change_left  <= 8'd0;
      err_short    <= 1'b0;
    end else begin
      cur          <= nxt;
      price        <= price_nxt;
      moneyv_prev  <= moneyv;
      timer        <= timer_nxt;
      disp_cnt     <= disp_cnt_nxt;
      phase        <= phase_nxt;
      acc_lock     <= (nxt != COLLECT);
      acc_rst      <= (nxt == CLEAR);
      dispense     <= (nxt == DISPENSE);
      change_pulse <= change_pulse_nxt;
      change_left  <= change_left_nxt;
      err_short    <= err_short_nxt;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_reseller_ctrl.sv
// Bench for reseller_ctrl: fixed vector table, directed multi-cycle sequences,
// and randomized traffic checked against a transaction-schedule reference model.
module tb_reseller_ctrl;

  localparam int DISP = 4;
  localparam int TMO  = 8;

  logic       cp;
  logic       rst;
  logic       sel_valid;
  logic [7:0] sel_price;
  logic       buy;
  logic       cancel;
  logic [7:0] moneyv;
  logic       acc_lock;
  logic       acc_rst;
  logic       dispense;
  logic       change_pulse;
  logic [7:0] change_left;
  logic       err_short;
  logic [2:0] state;

  int vectors    = 0;
  int miscompares = 0;

  reseller_ctrl #(.DISP_CYCLES(DISP), .TIMEOUT(TMO)) dut (
    .cp(cp), .rst(rst), .sel_valid(sel_valid), .sel_price(sel_price),
    .buy(buy), .cancel(cancel), .moneyv(moneyv),
    .acc_lock(acc_lock), .acc_rst(acc_rst), .dispense(dispense),
    .change_pulse(change_pulse), .change_left(change_left),
    .err_short(err_short), .state(state)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  typedef struct packed {
    logic [2:0] st;
    logic       lock;
    logic       arst;
    logic       disp;
    logic       pulse;
    logic [7:0] left;
    logic       err;
  } outs_t;

  typedef struct {
    logic       r;
    logic       sv;
    logic [7:0] sp;
    logic       b;
    logic       c;
    logic [7:0] mv;
    outs_t      exp;
  } vec_t;

  function automatic outs_t mk(int st, int lock, int arst, int disp, int pulse, int left, int err);
    outs_t o;
    o.st = 3'(st); o.lock = 1'(lock); o.arst = 1'(arst); o.disp = 1'(disp);
    o.pulse = 1'(pulse); o.left = 8'(left); o.err = 1'(err);
    return o;
  endfunction

  function automatic vec_t v(int r, int sv, int sp, int b, int c, int mv, outs_t e);
    vec_t x;
    x.r = 1'(r); x.sv = 1'(sv); x.sp = 8'(sp); x.b = 1'(b); x.c = 1'(c); x.mv = 8'(mv);
    x.exp = e;
    return x;
  endfunction

  // Reference model: while collecting it tracks price and idle cycles; once a
  // transaction resolves it lays out the whole remaining output schedule.
  outs_t      sched[$];
  outs_t      m_exp;
  bit         m_coll;
  logic [7:0] m_price;
  logic [7:0] m_prev;
  int         m_idle;

  function automatic void plan_change(int n);
    sched.push_back(mk(3, 1, 0, 0, 0, n, 0));
    for (int k = 1; k <= n; k++) begin
      sched.push_back(mk(3, 1, 0, 0, 1, n - k, 0));
      sched.push_back(mk(3, 1, 0, 0, 0, n - k, 0));
    end
    sched.push_back(mk(4, 1, 1, 0, 0, 0, 0));
    sched.push_back(mk(0, 1, 0, 0, 0, 0, 0));
  endfunction

  function automatic void model_edge();
    int ch;
    if (!rst) begin
      sched.delete();
      m_coll = 0;
      m_idle = 0;
      m_exp  = mk(0, 1, 1, 0, 0, 0, 0);
    end else if (sched.size() != 0) begin
      m_exp = sched.pop_front();
    end else if (m_coll) begin
      if (cancel || (!buy && moneyv == m_prev && m_idle == TMO - 1)) begin
        plan_change(int'(moneyv));
        m_coll = 0;
        m_exp  = sched.pop_front();
      end else if (buy && moneyv >= m_price) begin
        ch = int'(moneyv) - int'(m_price);
        for (int i = 0; i < DISP; i++) sched.push_back(mk(2, 1, 0, 1, 0, ch, 0));
        plan_change(ch);
        m_coll = 0;
        m_exp  = sched.pop_front();
      end else begin
        if (buy || moneyv != m_prev) m_idle = 0;
        else m_idle++;
        m_exp = mk(1, 0, 0, 0, 0, 0, int'(buy));
      end
    end else if (sel_valid && sel_price != 8'd0) begin
      m_price = sel_price;
      m_coll  = 1;
      m_idle  = 0;
      m_exp   = mk(1, 0, 0, 0, 0, 0, 0);
    end else begin
      m_exp = mk(0, 1, 0, 0, 0, 0, 0);
    end
    m_prev = rst ? moneyv : 8'd0;
  endfunction

  task automatic check_out(input string tag, input outs_t want);
    outs_t got;
    got = {state, acc_lock, acc_rst, dispense, change_pulse, change_left, err_short};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s @%0t: got st=%0d lock=%0b arst=%0b disp=%0b pulse=%0b left=%0d err=%0b, want st=%0d lock=%0b arst=%0b disp=%0b pulse=%0b left=%0d err=%0b",
               tag, $time, got.st, got.lock, got.arst, got.disp, got.pulse, got.left, got.err,
               want.st, want.lock, want.arst, want.disp, want.pulse, want.left, want.err);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  task automatic step(input int r, input int sv, input int sp, input int b, input int c,
                      input int mv, input string tag);
    rst = 1'(r); sel_valid = 1'(sv); sel_price = 8'(sp);
    buy = 1'(b); cancel = 1'(c); moneyv = 8'(mv);
    @(posedge cp);
    model_edge();
    #1;
    check_out(tag, m_exp);
  endtask

  // Drives ignored-in-this-state inputs until the FSM returns to IDLE.
  task automatic run_to_idle(input string tag, output int pulses, output int disps,
                             output int arsts, output int b2b);
    int  n;
    bit  last;
    pulses = 0; disps = 0; arsts = 0; b2b = 0; n = 0; last = 0;
    while (state != 3'd0 && n < 700) begin
      step(1, 1, 9, 1, 1, 77, tag);
      if (change_pulse) pulses++;
      if (dispense) disps++;
      if (acc_rst) arsts++;
      if (change_pulse && last) b2b++;
      last = change_pulse;
      n++;
    end
    if (state != 3'd0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_bound: state=%0d still not IDLE after %0d cycles", tag, state, n);
    end
  endtask

  vec_t tbl[$];

  initial begin
    int p, d, a, bb, n, d0;
    int sv_r, sp_r, b_r, c_r, r_r, mv_r;

    tbl.push_back(v(0, 1, 7, 1, 0, 0,   mk(0, 1, 1, 0, 0, 0, 0)));
    tbl.push_back(v(0, 1, 7, 1, 0, 0,   mk(0, 1, 1, 0, 0, 0, 0)));
    tbl.push_back(v(0, 1, 7, 1, 0, 0,   mk(0, 1, 1, 0, 0, 0, 0)));
    tbl.push_back(v(1, 0, 0, 0, 0, 0,   mk(0, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(v(1, 1, 0, 0, 0, 0,   mk(0, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(v(1, 1, 11, 0, 0, 0,  mk(1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(1, 0, 0, 0, 0, 1,   mk(1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(1, 0, 0, 0, 0, 11,  mk(1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(1, 0, 0, 1, 0, 11,  mk(2, 1, 0, 1, 0, 0, 0)));
    tbl.push_back(v(1, 0, 0, 0, 1, 11,  mk(2, 1, 0, 1, 0, 0, 0)));
    tbl.push_back(v(1, 0, 0, 0, 1, 11,  mk(2, 1, 0, 1, 0, 0, 0)));
    tbl.push_back(v(1, 0, 0, 0, 1, 11,  mk(2, 1, 0, 1, 0, 0, 0)));
    tbl.push_back(v(1, 0, 0, 0, 0, 11,  mk(3, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(v(1, 1, 9, 0, 0, 0,   mk(4, 1, 1, 0, 0, 0, 0)));
    tbl.push_back(v(1, 0, 0, 0, 0, 0,   mk(0, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(v(1, 1, 12, 0, 0, 10, mk(1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(1, 0, 0, 1, 0, 10,  mk(1, 0, 0, 0, 0, 0, 1)));
    tbl.push_back(v(1, 0, 0, 0, 0, 10,  mk(1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(v(1, 0, 0, 1, 1, 10,  mk(3, 1, 0, 0, 0, 10, 0)));

    rst = 1'b0; sel_valid = 1'b0; sel_price = 8'd0; buy = 1'b0; cancel = 1'b0; moneyv = 8'd0;
    m_exp = mk(0, 1, 1, 0, 0, 0, 0); m_coll = 0; m_price = 8'd0; m_prev = 8'd0; m_idle = 0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(int'(tbl[i].r), int'(tbl[i].sv), int'(tbl[i].sp), int'(tbl[i].b),
           int'(tbl[i].c), int'(tbl[i].mv), "model_tbl");
      check_out($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // refund of 10 after cancel+buy
    run_to_idle("cancel_refund", p, d, a, bb);
    chk_int("cancel_pulses", p, 10);
    chk_int("cancel_disp", d, 0);
    chk_int("cancel_accrst", a, 1);
    chk_int("cancel_b2b", bb, 0);

    // overpay 20 for price 5
    step(1, 1, 5, 0, 0, 0, "overpay");
    step(1, 0, 0, 0, 0, 20, "overpay");
    step(1, 0, 0, 1, 0, 20, "overpay");
    chk_int("overpay_left", int'(change_left), 15);
    d0 = int'(dispense);
    run_to_idle("overpay", p, d, a, bb);
    chk_int("overpay_disp", d + d0, 4);
    chk_int("overpay_pulses", p, 15);
    chk_int("overpay_b2b", bb, 0);
    chk_int("overpay_accrst", a, 1);

    // timeout with constant money
    step(1, 1, 3, 0, 0, 2, "tmo");
    n = 0;
    do begin step(1, 0, 0, 0, 0, 2, "tmo"); n++; end while (state == 3'd1 && n < 50);
    chk_int("tmo_cycles", n, 8);
    chk_int("tmo_left", int'(change_left), 2);
    run_to_idle("tmo", p, d, a, bb);
    chk_int("tmo_pulses", p, 2);

    // timeout restarted by a money change on the fifth cycle
    step(1, 1, 3, 0, 0, 2, "tmo2");
    n = 0;
    do begin n++; step(1, 0, 0, 0, 0, (n >= 5) ? 3 : 2, "tmo2"); end while (state == 3'd1 && n < 50);
    chk_int("tmo2_cycles", n, 13);
    run_to_idle("tmo2", p, d, a, bb);
    chk_int("tmo2_pulses", p, 3);

    // exact buy at the 8-bit maximum
    step(1, 1, 255, 0, 0, 255, "max");
    step(1, 0, 0, 1, 0, 255, "max");
    chk_int("max_state", int'(state), 2);
    chk_int("max_left", int'(change_left), 0);
    run_to_idle("max", p, d, a, bb);
    chk_int("max_pulses", p, 0);

    // reset in the middle of paying change
    step(1, 1, 1, 0, 0, 9, "rstmid");
    step(1, 0, 0, 1, 0, 9, "rstmid");
    p = 0; n = 0;
    while (p < 3 && n < 100) begin
      step(1, 0, 0, 0, 0, 9, "rstmid");
      if (change_pulse) p++;
      n++;
    end
    chk_int("rstmid_pulses_before", p, 3);
    step(0, 0, 0, 0, 0, 9, "rstmid");
    step(0, 0, 0, 0, 0, 9, "rstmid");
    chk_int("rstmid_left", int'(change_left), 0);
    chk_int("rstmid_accrst", int'(acc_rst), 1);
    p = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 0, 0, 9, "rstmid_after");
      if (change_pulse) p++;
    end
    chk_int("rstmid_pulses_after", p, 0);
    chk_int("rstmid_state", int'(state), 0);

    // randomized traffic against the model
    mv_r = 0;
    for (int i = 0; i < 4000; i++) begin
      r_r  = ($urandom_range(0, 299) != 0) ? 1 : 0;
      sv_r = ($urandom_range(0, 3) == 0) ? 1 : 0;
      case ($urandom_range(0, 9))
        0:       sp_r = 0;
        1:       sp_r = 255;
        default: sp_r = int'($urandom_range(1, 25));
      endcase
      b_r = ($urandom_range(0, 7) == 0) ? 1 : 0;
      c_r = ($urandom_range(0, 39) == 0) ? 1 : 0;
      if ($urandom_range(0, 5) == 0)
        mv_r = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 30));
      step(r_r, sv_r, sp_r, b_r, c_r, mv_r, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
